// File: rtl/stack_unit.sv
// Operand stack for the stack-machine datapath: push/pop/peek/replace with a
// registered dout and sticky overflow/underflow flags.
module stack_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     tos,
   input  logic                     clr_err,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     ovf,
   output logic                     unf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    sp;
   logic [CW-1:0]    sp_m1;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;

   logic do_push;
   logic do_pop;
   logic do_replace;
   logic do_peek;
   logic set_ovf;
   logic set_unf;

   assign count   = sp;
   assign empty   = (sp == '0);
   assign full    = (sp == CW'(DEPTH));
   assign sp_m1   = sp - CW'(1);
   assign top_idx = sp_m1[AW-1:0];
   assign wr_idx  = sp[AW-1:0];

   always_comb begin
      do_push    = 1'b0;
      do_pop     = 1'b0;
      do_replace = 1'b0;
      do_peek    = 1'b0;
      set_ovf    = 1'b0;
      set_unf    = 1'b0;
      unique case ({push, pop})
         2'b10: begin
            do_push = !full;
            set_ovf = full;
         end
         2'b01: begin
            do_pop  = !empty;
            set_unf = empty;
         end
         2'b11: begin
            do_replace = !empty;
            set_unf    = empty;
         end
         default: do_peek = tos && !empty;
      endcase
   end

   // Storage is deliberately unreset; only entries below sp are ever read.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_idx] <= din;
      else if (do_replace)
         mem[top_idx] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp   <= '0;
         dout <= '0;
         ovf  <= 1'b0;
         unf  <= 1'b0;
      end else begin
         if (do_push)
            sp <= sp + CW'(1);
         else if (do_pop)
            sp <= sp_m1;

         if (do_pop || do_replace || do_peek)
            dout <= mem[top_idx];

         // An error event in the same cycle as clr_err keeps the flag set.
         if (set_ovf)
            ovf <= 1'b1;
         else if (clr_err)
            ovf <= 1'b0;

         if (set_unf)
            unf <= 1'b1;
         else if (clr_err)
            unf <= 1'b0;
      end
   end

endmodule
